// File: rtl/sym_game_pkg.sv
// Shared definitions for the symbol-counter game: state encoding and default
// phase timings used by the sequencer and the display logic.
package sym_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PLAY      = 2'd2,
        ST_RESULT    = 2'd3
    } game_state_e;

    localparam logic [31:0] PRE_TICKS_DEF    = 32'd300000000;
    localparam logic [31:0] PLAY_TICKS_DEF   = 32'd1000000000;
    localparam logic [31:0] RESULT_TICKS_DEF = 32'd200000000;
    localparam logic [31:0] MAX_START_DEF    = 32'd50000000;
    localparam logic [31:0] MAX_STEP_DEF     = 32'd5000000;
    localparam logic [31:0] MAX_MIN_DEF      = 32'd10000000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 value_q <= '0;
        else if (clr)               value_q <= '0;
        else if (inc && ~&value_q)  value_q <= value_q + 1'b1;
    end

    assign value = value_q;

endmodule

// File: rtl/sym_game_ctrl.sv
// Game sequencer: runs countdown/play/result phases, tallies generator specials
// against player presses, and adjusts level and generation period per round.
module sym_game_ctrl
    import sym_game_pkg::*;
#(
    parameter logic [31:0] PRE_TICKS    = PRE_TICKS_DEF,
    parameter logic [31:0] PLAY_TICKS   = PLAY_TICKS_DEF,
    parameter logic [31:0] RESULT_TICKS = RESULT_TICKS_DEF,
    parameter logic [31:0] MAX_START    = MAX_START_DEF,
    parameter logic [31:0] MAX_STEP     = MAX_STEP_DEF,
    parameter logic [31:0] MAX_MIN      = MAX_MIN_DEF,
    parameter int          CNT_W        = 8,
    parameter int          LVL_W        = 4
) (
    input  logic             Clk100M,
    input  logic             Rst_n,
    input  logic             StartBtn,
    input  logic             CountBtn,
    input  logic             generated,
    input  logic             special,
    output logic             genSym,
    output logic [31:0]      symGenMax,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] specialCount,
    output logic [CNT_W-1:0] userCount,
    output logic [LVL_W-1:0] level,
    output logic             win,
    output logic             lose
);

    game_state_e      state_q, state_d;
    logic [31:0]      timer_q, timer_d;
    logic [31:0]      max_q, max_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             drain_q, drain_d;
    logic             win_q, win_d, lose_q, lose_d;
    logic             gen_q;
    logic             clr_cnt, inc_spec, inc_user, match_now;
    logic [CNT_W-1:0] spec_final;
    logic [32:0]      dec33;
    logic [31:0]      floor_max;

    // The generator's registered outputs lag by one cycle, so the first RESULT
    // cycle still accepts a trailing special.
    assign inc_spec = special & ((state_q == ST_PLAY) | ((state_q == ST_RESULT) & drain_q));
    assign inc_user = CountBtn & (state_q == ST_PLAY);

    sat_counter #(.W(CNT_W)) u_spec_cnt (
        .clk(Clk100M), .rst_n(Rst_n), .clr(clr_cnt), .inc(inc_spec), .value(specialCount)
    );

    sat_counter #(.W(CNT_W)) u_user_cnt (
        .clk(Clk100M), .rst_n(Rst_n), .clr(clr_cnt), .inc(inc_user), .value(userCount)
    );

    // Value the special tally takes at the end of the drain cycle.
    assign spec_final = specialCount + {{(CNT_W-1){1'b0}}, (inc_spec & ~&specialCount)};
    assign match_now  = (spec_final == userCount);

    assign dec33     = {1'b0, max_q} - {1'b0, MAX_STEP};
    assign floor_max = (dec33[32] || (dec33[31:0] < MAX_MIN)) ? MAX_MIN : dec33[31:0];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        drain_d = 1'b0;
        win_d   = win_q;
        lose_d  = lose_q;
        level_d = level_q;
        max_d   = max_q;
        clr_cnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (StartBtn) begin
                    state_d = ST_COUNTDOWN;
                    timer_d = PRE_TICKS - 32'd1;
                    clr_cnt = 1'b1;
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                end
            end
            ST_COUNTDOWN: begin
                if (timer_q == '0) begin
                    state_d = ST_PLAY;
                    timer_d = PLAY_TICKS - 32'd1;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            ST_PLAY: begin
                if (timer_q == '0) begin
                    state_d = ST_RESULT;
                    timer_d = RESULT_TICKS - 32'd1;
                    drain_d = 1'b1;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            ST_RESULT: begin
                if (drain_q) begin
                    win_d  = match_now;
                    lose_d = ~match_now;
                end
                // win_d already reflects the drain verdict if RESULT lasts one cycle.
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                    if (win_d) begin
                        level_d = (&level_q) ? level_q : level_q + 1'b1;
                        max_d   = floor_max;
                    end else begin
                        level_d = '0;
                        max_d   = MAX_START;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            max_q   <= MAX_START;
            level_q <= '0;
            drain_q <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            gen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            max_q   <= max_d;
            level_q <= level_d;
            drain_q <= drain_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            gen_q   <= (state_d == ST_PLAY);
        end
    end

    assign genSym    = gen_q;
    assign symGenMax = max_q;
    assign state     = state_q;
    assign level     = level_q;
    assign win       = win_q;
    assign lose      = lose_q;

endmodule

// File: tb/tb_sym_game_ctrl.sv
// Directed bench for sym_game_ctrl: per-cycle vector table for one round plus
// hand sequences for reset, level progression, period floor and saturation.
module tb_sym_game_ctrl;

    localparam logic [31:0] M0 = 32'd50000000;
    localparam logic [31:0] M1 = 32'd45000000;
    localparam logic [31:0] M2 = 32'd40000000;

    logic Clk100M = 1'b0;
    logic Rst_n, StartBtn, CountBtn, generated, special;
    logic start3, spec3;

    logic        gen_a, gen_b, gen_c;
    logic [31:0] max_a, max_b, max_c;
    logic [1:0]  st_a, st_b, st_c;
    logic [7:0]  sc_a, uc_a, sc_b, uc_b, sc_c, uc_c;
    logic [3:0]  lv_a, lv_b, lv_c;
    logic        w_a, l_a, w_b, l_b, w_c, l_c;

    int errs = 0;
    int checks = 0;

    always #5 Clk100M = ~Clk100M;

    sym_game_ctrl #(.PRE_TICKS(3), .PLAY_TICKS(10), .RESULT_TICKS(4)) dut (
        .Clk100M(Clk100M), .Rst_n(Rst_n), .StartBtn(StartBtn), .CountBtn(CountBtn),
        .generated(generated), .special(special), .genSym(gen_a), .symGenMax(max_a),
        .state(st_a), .specialCount(sc_a), .userCount(uc_a), .level(lv_a), .win(w_a), .lose(l_a));

    sym_game_ctrl #(.PRE_TICKS(3), .PLAY_TICKS(10), .RESULT_TICKS(4),
                    .MAX_START(12), .MAX_STEP(5), .MAX_MIN(10)) dut2 (
        .Clk100M(Clk100M), .Rst_n(Rst_n), .StartBtn(StartBtn), .CountBtn(CountBtn),
        .generated(generated), .special(special), .genSym(gen_b), .symGenMax(max_b),
        .state(st_b), .specialCount(sc_b), .userCount(uc_b), .level(lv_b), .win(w_b), .lose(l_b));

    sym_game_ctrl #(.PRE_TICKS(3), .PLAY_TICKS(310), .RESULT_TICKS(4)) dut3 (
        .Clk100M(Clk100M), .Rst_n(Rst_n), .StartBtn(start3), .CountBtn(1'b0),
        .generated(1'b0), .special(spec3), .genSym(gen_c), .symGenMax(max_c),
        .state(st_c), .specialCount(sc_c), .userCount(uc_c), .level(lv_c), .win(w_c), .lose(l_c));

    typedef struct {
        logic        st, cn, sp;
        logic [1:0]  s;
        logic        g;
        logic [7:0]  sc, uc;
        logic        w, l;
        logic [3:0]  lv;
        logic [31:0] mx;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic st, input logic cn, input logic sp, input int s,
                                input logic g, input int sc, input int uc, input logic w,
                                input logic l, input int lv, input logic [31:0] mx);
        vec_t v;
        v.st = st; v.cn = cn; v.sp = sp; v.s = 2'(s); v.g = g;
        v.sc = 8'(sc); v.uc = 8'(uc); v.w = w; v.l = l; v.lv = 4'(lv); v.mx = mx;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk100M);
        #1;
    endtask

    // One full round on dut/dut2: ns specials and np presses in the first PLAY cycles.
    task automatic run_round(input int ns, input int np, input logic exp_win, input string tag);
        StartBtn = 1'b1; step(); StartBtn = 1'b0;
        chk({tag, ".win_clr"}, 32'(w_a), 0);
        repeat (3) step();
        chk({tag, ".play"}, 32'(st_a), 2);
        for (int i = 0; i < 10; i++) begin
            special  = (i < ns);
            CountBtn = (i < np);
            step();
        end
        special = 1'b0; CountBtn = 1'b0;
        chk({tag, ".result"}, 32'(st_a), 3);
        step();
        chk({tag, ".win"}, 32'(w_a), 32'(exp_win));
        chk({tag, ".lose"}, 32'(l_a), 32'(!exp_win));
        repeat (3) step();
        chk({tag, ".idle"}, 32'(st_a), 0);
    endtask

    initial begin
        Rst_n = 1'b0; StartBtn = 1'b0; CountBtn = 1'b0; generated = 1'b0; special = 1'b0;
        start3 = 1'b0; spec3 = 1'b0;

        tbl[0]  = mk(1,0,0, 1,0, 0,0, 0,0, 0, M0);
        tbl[1]  = mk(0,1,0, 1,0, 0,0, 0,0, 0, M0);
        tbl[2]  = mk(0,0,0, 1,0, 0,0, 0,0, 0, M0);
        tbl[3]  = mk(0,0,0, 2,1, 0,0, 0,0, 0, M0);
        tbl[4]  = mk(0,1,0, 2,1, 0,1, 0,0, 0, M0);
        tbl[5]  = mk(0,0,1, 2,1, 1,1, 0,0, 0, M0);
        tbl[6]  = mk(0,1,0, 2,1, 1,2, 0,0, 0, M0);
        tbl[7]  = mk(1,0,0, 2,1, 1,2, 0,0, 0, M0);
        tbl[8]  = mk(0,0,0, 2,1, 1,2, 0,0, 0, M0);
        tbl[9]  = mk(0,1,1, 2,1, 2,3, 0,0, 0, M0);
        tbl[10] = mk(0,0,0, 2,1, 2,3, 0,0, 0, M0);
        tbl[11] = mk(0,0,0, 2,1, 2,3, 0,0, 0, M0);
        tbl[12] = mk(0,0,0, 2,1, 2,3, 0,0, 0, M0);
        tbl[13] = mk(0,0,0, 3,0, 2,3, 0,0, 0, M0);
        tbl[14] = mk(0,1,1, 3,0, 3,3, 1,0, 0, M0);
        tbl[15] = mk(0,1,0, 3,0, 3,3, 1,0, 0, M0);
        tbl[16] = mk(0,0,0, 3,0, 3,3, 1,0, 0, M0);
        tbl[17] = mk(0,0,0, 0,0, 3,3, 1,0, 1, M1);

        #12;
        chk("rst.state", 32'(st_a), 0);
        chk("rst.gen", 32'(gen_a), 0);
        chk("rst.max", max_a, M0);
        chk("rst.sc", 32'(sc_a), 0);
        chk("rst.uc", 32'(uc_a), 0);
        chk("rst.level", 32'(lv_a), 0);
        chk("rst.win", 32'(w_a), 0);
        chk("rst.lose", 32'(l_a), 0);
        Rst_n = 1'b1;
        step();

        // Matched round, cycle by cycle.
        for (int i = 0; i < 18; i++) begin
            StartBtn = tbl[i].st; CountBtn = tbl[i].cn; special = tbl[i].sp;
            generated = tbl[i].sp;
            step();
            chk($sformatf("row%0d.state", i), 32'(st_a), 32'(tbl[i].s));
            chk($sformatf("row%0d.gen", i), 32'(gen_a), 32'(tbl[i].g));
            chk($sformatf("row%0d.sc", i), 32'(sc_a), 32'(tbl[i].sc));
            chk($sformatf("row%0d.uc", i), 32'(uc_a), 32'(tbl[i].uc));
            chk($sformatf("row%0d.win", i), 32'(w_a), 32'(tbl[i].w));
            chk($sformatf("row%0d.lose", i), 32'(l_a), 32'(tbl[i].l));
            chk($sformatf("row%0d.level", i), 32'(lv_a), 32'(tbl[i].lv));
            chk($sformatf("row%0d.max", i), max_a, tbl[i].mx);
        end
        StartBtn = 1'b0; CountBtn = 1'b0; special = 1'b0; generated = 1'b0;
        chk("floor.first", max_b, 10);

        run_round(1, 1, 1'b1, "win2");
        chk("win2.level", 32'(lv_a), 2);
        chk("win2.max", max_a, M2);
        chk("floor.hold", max_b, 10);

        // Abort mid-PLAY with asynchronous reset.
        StartBtn = 1'b1; step(); StartBtn = 1'b0;
        repeat (3) step();
        special = 1'b1; CountBtn = 1'b1; step();
        special = 1'b0; CountBtn = 1'b0; repeat (3) step();
        chk("mid.play", 32'(st_a), 2);
        chk("mid.sc", 32'(sc_a), 1);
        Rst_n = 1'b0;
        #2;
        chk("mid.state", 32'(st_a), 0);
        chk("mid.gen", 32'(gen_a), 0);
        chk("mid.max", max_a, M0);
        chk("mid.level", 32'(lv_a), 0);
        chk("mid.sc0", 32'(sc_a), 0);
        chk("mid.uc0", 32'(uc_a), 0);
        chk("mid.win", 32'(w_a), 0);
        chk("mid.max2", max_b, 12);
        Rst_n = 1'b1;
        step();

        run_round(0, 0, 1'b1, "wa");
        run_round(1, 1, 1'b1, "wb");
        chk("wb.level", 32'(lv_a), 2);
        run_round(2, 1, 1'b0, "mis");
        chk("mis.sc", 32'(sc_a), 2);
        chk("mis.uc", 32'(uc_a), 1);
        chk("mis.level", 32'(lv_a), 0);
        chk("mis.max", max_a, M0);
        chk("mis.max2", max_b, 12);
        chk("mis.lose_held", 32'(l_a), 1);

        // Saturation: 300 specials inside a 310-cycle window.
        start3 = 1'b1; step(); start3 = 1'b0;
        repeat (3) step();
        chk("sat.play", 32'(st_c), 2);
        spec3 = 1'b1;
        repeat (300) step();
        spec3 = 1'b0;
        chk("sat.sc", 32'(sc_c), 255);
        chk("sat.uc", 32'(uc_c), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
